// File: rtl/instr_queue_if.sv
// instr_queue_if: enqueue (fetch frontend) and dequeue (decode/rename)
// handshake bundle for instr_queue. The master side drives the enqueue
// fields and deq_ready; the slave side is the queue itself.
interface instr_queue_if #(
   parameter int unsigned COB_ADDR_WIDTH = 3,
   parameter int unsigned COB_DEPTH      = 8
);
   logic                      enq_valid;
   logic [31:0]               enq_pc;
   logic [31:0]               enq_instr;
   logic [COB_ADDR_WIDTH-1:0] enq_tag;
   logic [COB_DEPTH-1:0]      enq_mask;
   logic                      iqueue_full;
   logic                      deq_valid;
   logic                      deq_ready;
   logic [31:0]               deq_pc;
   logic [31:0]               deq_instr;
   logic [COB_ADDR_WIDTH-1:0] deq_tag;
   logic [COB_DEPTH-1:0]      deq_mask;

   modport master (
      output enq_valid, enq_pc, enq_instr, enq_tag, enq_mask, deq_ready,
      input  iqueue_full, deq_valid, deq_pc, deq_instr, deq_tag, deq_mask
   );

   modport slave (
      input  enq_valid, enq_pc, enq_instr, enq_tag, enq_mask, deq_ready,
      output iqueue_full, deq_valid, deq_pc, deq_instr, deq_tag, deq_mask
   );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: in-order instruction buffer between fetch and decode/rename.
// Circular buffer with per-entry branch masks; branch "clean" clears a mask
// bit in every entry, branch "kill" marks dependent entries dead, and dead
// entries at the head drain one per cycle without a consumer handshake.
// Optional feature macro IQUEUE_BYPASS_EN: an empty queue forwards the
// enqueue fields straight to the dequeue side in the same cycle.
module instr_queue #(
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned COB_ADDR_WIDTH = 3,
   parameter int unsigned COB_DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   instr_queue_if.slave              bus,
   input  logic                      br_broadcast,
   input  logic                      br_clean,
   input  logic                      br_kill,
   input  logic [COB_ADDR_WIDTH-1:0] br_tag,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]          head;
   logic [PTR_W-1:0]          tail;
   logic [DEPTH-1:0]          live;
   logic [DEPTH-1:0]          live_next;
   logic [31:0]               pc_mem    [DEPTH];
   logic [31:0]               instr_mem [DEPTH];
   logic [COB_ADDR_WIDTH-1:0] tag_mem   [DEPTH];
   logic [COB_DEPTH-1:0]      mask_mem  [DEPTH];

   logic                 kill;
   logic                 clean;
   logic                 full;
   logic                 not_empty;
   logic                 head_hit;
   logic                 enq_hit;
   logic                 queue_valid;
   logic                 bypass;
   logic                 bypass_take;
   logic                 pop;
   logic                 write;
   logic [COB_DEPTH-1:0] tag_bit;
   logic [COB_DEPTH-1:0] enq_mask_c;
   logic [COB_DEPTH-1:0] head_mask_c;

   // Broadcast decode, head status, and push/pop decisions
   always_comb begin
      kill      = br_broadcast & br_kill;
      clean     = br_broadcast & br_clean & ~br_kill;
      tag_bit   = '0;
      tag_bit[br_tag] = 1'b1;
      full      = (count == (PTR_W+1)'(DEPTH));
      not_empty = (count != '0);
      head_hit  = kill & |(mask_mem[head] & tag_bit);
      enq_hit   = kill & |(bus.enq_mask & tag_bit);
      enq_mask_c  = clean ? (bus.enq_mask & ~tag_bit) : bus.enq_mask;
      head_mask_c = clean ? (mask_mem[head] & ~tag_bit) : mask_mem[head];
      queue_valid = not_empty & live[head] & ~head_hit;
`ifdef IQUEUE_BYPASS_EN
      bypass = ~not_empty & bus.enq_valid;
`else
      bypass = 1'b0;
`endif
      bypass_take = bypass & ~enq_hit & bus.deq_ready;
      // Dead heads pop on their own; live heads need the consumer
      pop   = not_empty & (~live[head] | (queue_valid & bus.deq_ready));
      write = bus.enq_valid & ~full & ~bypass_take;
   end

   // Dequeue-side outputs: queue head, or the incoming word when bypassing
   always_comb begin
      bus.iqueue_full = full;
      if (bypass) begin
         bus.deq_valid = ~enq_hit;
         bus.deq_pc    = bus.enq_pc;
         bus.deq_instr = bus.enq_instr;
         bus.deq_tag   = bus.enq_tag;
         bus.deq_mask  = enq_mask_c;
      end else begin
         bus.deq_valid = queue_valid;
         bus.deq_pc    = pc_mem[head];
         bus.deq_instr = instr_mem[head];
         bus.deq_tag   = tag_mem[head];
         bus.deq_mask  = head_mask_c;
      end
   end

   // Next live bits: kill clears matching slots, a write sets the tail slot
   always_comb begin
      live_next = live;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (kill && mask_mem[i][br_tag]) live_next[i] = 1'b0;
      end
      if (write) live_next[tail] = ~enq_hit;
   end

   // Pointers, occupancy and live bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         live  <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         live  <= '0;
      end else begin
         if (pop)   head <= head + PTR_W'(1);
         if (write) tail <= tail + PTR_W'(1);
         count <= count + (PTR_W+1)'(write) - (PTR_W+1)'(pop);
         live  <= live_next;
      end
   end

   // Payload storage; masks of all slots follow branch clean broadcasts
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (clean) begin
            for (int unsigned i = 0; i < DEPTH; i++) mask_mem[i][br_tag] <= 1'b0;
         end
         if (write) begin
            pc_mem[tail]    <= bus.enq_pc;
            instr_mem[tail] <= bus.enq_instr;
            tag_mem[tail]   <= bus.enq_tag;
            mask_mem[tail]  <= enq_mask_c;
         end
      end
   end

   overflow_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.enq_valid && full && !flush))
      else $warning("instr_queue: enq_valid while full, instruction dropped");

   clean_kill_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(br_broadcast && br_clean && br_kill));

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scenarios plus randomized traffic, checked
// against a queue-of-entries reference model.
module tb_instr_queue;
   localparam int DEPTH = 16;

   typedef struct {
      logic        live;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [2:0]  tag;
      logic [7:0]  mask;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       br_broadcast = 1'b0;
   logic       br_clean = 1'b0;
   logic       br_kill = 1'b0;
   logic [2:0] br_tag = '0;
   logic [4:0] count;

   int checks = 0;
   int errors = 0;
   ent_t q[$];

   instr_queue_if #(.COB_ADDR_WIDTH(3), .COB_DEPTH(8)) bus ();

   instr_queue #(.DEPTH(DEPTH), .COB_ADDR_WIDTH(3), .COB_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
      .br_broadcast(br_broadcast), .br_clean(br_clean), .br_kill(br_kill),
      .br_tag(br_tag), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      bus.enq_valid = 1'b0; bus.deq_ready = 1'b0; flush = 1'b0;
      br_broadcast = 1'b0; br_clean = 1'b0; br_kill = 1'b0; br_tag = '0;
   endtask

   // One clock: drive at negedge, check against the model, advance the model
   task automatic step(input logic ev, input logic [31:0] pc, input logic [7:0] m,
                       input logic rdy, input logic fl, input logic bb,
                       input logic bc, input logic bk, input logic [2:0] bt);
      int          sz;
      logic        byp, kl, cl, exp_v, pop, push, taken;
      logic [7:0]  exp_mask;
      logic [31:0] ins;
      logic [2:0]  etag;
      ent_t        e, t;
      ins  = $urandom;
      etag = 3'($urandom);
      @(negedge clk);
      bus.enq_valid = ev; bus.enq_pc = pc; bus.enq_instr = ins;
      bus.enq_tag = etag; bus.enq_mask = m; bus.deq_ready = rdy;
      flush = fl; br_broadcast = bb; br_clean = bc; br_kill = bk; br_tag = bt;
      #1;
      sz = q.size();
      kl = bb && bk;
      cl = bb && bc && !bk;
      byp = 1'b0;
`ifdef IQUEUE_BYPASS_EN
      byp = (sz == 0) && ev;
`endif
      e = '{1'b0, 32'h0, 32'h0, 3'h0, 8'h0};
      exp_v = 1'b0;
      if (byp) begin
         e = '{1'b1, pc, ins, etag, m};
         exp_v = !(kl && m[bt]);
      end else if (sz > 0) begin
         e = q[0];
         exp_v = e.live && !(kl && e.mask[bt]);
      end
      exp_mask = e.mask;
      if (cl) exp_mask[bt] = 1'b0;
      check("count", 64'(count), 64'(sz));
      check("full", 64'(bus.iqueue_full), 64'(sz == DEPTH));
      check("deq_valid", 64'(bus.deq_valid), 64'(exp_v));
      if (exp_v) begin
         check("deq_pc", 64'(bus.deq_pc), 64'(e.pc));
         check("deq_instr", 64'(bus.deq_instr), 64'(e.instr));
         check("deq_tag", 64'(bus.deq_tag), 64'(e.tag));
         check("deq_mask", 64'(bus.deq_mask), 64'(exp_mask));
      end
      if (fl) begin
         q.delete();
      end else begin
         pop   = (sz > 0) && (!q[0].live || (exp_v && rdy));
         taken = byp && exp_v && rdy;
         push  = ev && (sz < DEPTH) && !taken;
         for (int i = 0; i < sz; i++) begin
            t = q[i];
            if (kl && t.mask[bt]) t.live = 1'b0;
            if (cl) t.mask[bt] = 1'b0;
            q[i] = t;
         end
         if (pop) void'(q.pop_front());
         if (push) begin
            t = '{!(kl && m[bt]), pc, ins, etag, m};
            if (cl) t.mask[bt] = 1'b0;
            q.push_back(t);
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 8'h0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic enq(input logic [31:0] pc, input logic [7:0] m);
      step(1'b1, pc, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() > 0; i++) idle(1'b1);
      check("drain_done", 64'(q.size()), 64'd0);
   endtask

   initial begin
      logic       ev, rdy, fl, bb, bc, bk;
      logic [7:0] m;
      set_idle();
      bus.enq_pc = '0; bus.enq_instr = '0; bus.enq_tag = '0; bus.enq_mask = '0;
      #12;
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(bus.deq_valid), 64'd0);
      check("rst_full", 64'(bus.iqueue_full), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // In-order delivery
      enq(32'h1000, 8'h00); enq(32'h1004, 8'h00); enq(32'h1008, 8'h00);
      idle(1'b0);
      check("t1_count", 64'(count), 64'd3);
      check("t1_head_pc", 64'(bus.deq_pc), 64'h1000);
      idle(1'b1); idle(1'b1); idle(1'b1);
      idle(1'b0);
      check("t1_empty_valid", 64'(bus.deq_valid), 64'd0);

      // Fill, overflow attempt, pop, wrap
      for (int i = 0; i < DEPTH; i++) enq(32'h3000 + 32'(i * 4), 8'h00);
      idle(1'b0);
      check("t2_full", 64'(bus.iqueue_full), 64'd1);
      enq(32'hDEAD_0000, 8'h00);
      idle(1'b0);
      check("t2_count_after_drop", 64'(count), 64'd16);
      idle(1'b1);
      idle(1'b0);
      check("t2_not_full", 64'(bus.iqueue_full), 64'd0);
      for (int i = 0; i < 4; i++) enq(32'h4000 + 32'(i * 4), 8'h00);
      drain();

      // Clean clears mask bit everywhere
      enq(32'h5000, 8'h00); enq(32'h5004, 8'h04); enq(32'h5008, 8'h04);
      step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
      drain();
      enq(32'h5100, 8'h04); enq(32'h5104, 8'h04);
      step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
      check("t3_same_cycle_mask", 64'(bus.deq_mask), 64'h00);
      drain();

      // Kill squashes dependent entries
      enq(32'h6000, 8'h00); enq(32'h6004, 8'h02); enq(32'h6008, 8'h02);
      step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
      idle(1'b1); idle(1'b1); idle(1'b1);
      idle(1'b0);
      check("t4_count_zero", 64'(count), 64'd0);

      // Flush, then asynchronous reset
      for (int i = 0; i < 5; i++) enq(32'h7000 + 32'(i * 4), 8'h01);
      step(1'b1, 32'h7100, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
      idle(1'b0);
      check("t5_flush_count", 64'(count), 64'd0);
      check("t5_flush_valid", 64'(bus.deq_valid), 64'd0);
      enq(32'h7200, 8'h00); enq(32'h7204, 8'h00); enq(32'h7208, 8'h00);
      @(negedge clk);
      set_idle();
      #2 rst_n = 1'b0;
      #1;
      check("t5_arst_count", 64'(count), 64'd0);
      check("t5_arst_valid", 64'(bus.deq_valid), 64'd0);
      check("t5_arst_full", 64'(bus.iqueue_full), 64'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Empty-queue latency
      step(1'b1, 32'h2000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      idle(1'b1);
`ifdef IQUEUE_BYPASS_EN
      check("t6_bypass_count", 64'(count), 64'd0);
`else
      check("t6_late_pc", 64'(bus.deq_pc), 64'h2000);
      check("t6_late_valid", 64'(bus.deq_valid), 64'd1);
`endif
      drain();

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         ev  = ($urandom_range(0, 9) < 6) && (q.size() < DEPTH);
         rdy = ($urandom_range(0, 1) == 1);
         fl  = ($urandom_range(0, 49) == 0);
         bb  = ($urandom_range(0, 4) == 0);
         bk  = bb && ($urandom_range(0, 1) == 1);
         bc  = bb && !bk;
         m   = 8'($urandom) & 8'($urandom);
         step(ev, $urandom, m, rdy, fl, bb, bc, bk, 3'($urandom));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Instruction queue directly downstream of the fetch frontend.
- Captures fetched words (pc, instruction, branch tag, branch mask) when the frontend asserts instr_ready, and presents them in order to decode/rename over a valid/ready handshake.
- Drives the queue-full back-pressure the frontend stalls on.
- Tracks branch speculation per entry: clears mask bits on branch-resolution "clean" and squashes dependent entries on "kill".

Parameters:
DEPTH, 16, number of entries; power of two, >= 2.
COB_ADDR_WIDTH, 3, branch tag width; matches backend_types.
COB_DEPTH, 8, branch mask width; equals 2**COB_ADDR_WIDTH.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of all entries (frontend flush).
enq_valid  in  1  frontend instr_ready.
enq_pc  in  32  fetch pc.
enq_instr  in  32  imem_rdata.
enq_tag  in  COB_ADDR_WIDTH  branch_tag of the instruction.
enq_mask  in  COB_DEPTH  branch_mask of the instruction.
iqueue_full  out  1  count == DEPTH.
deq_valid  out  1  head holds a live instruction.
deq_ready  in  1  consumer accepts the head.
deq_pc  out  32  head pc.
deq_instr  out  32  head instruction.
deq_tag  out  COB_ADDR_WIDTH  head branch tag.
deq_mask  out  COB_DEPTH  head mask with the current-cycle clean applied.
br_broadcast  in  1  resolution bus valid.
br_clean  in  1  resolved branch predicted correctly.
br_kill  in  1  resolved branch mispredicted.
br_tag  in  COB_ADDR_WIDTH  resolved branch tag.
count  out  $clog2(DEPTH)+1  number of occupied slots, live or dead.

Behaviour:
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus a count register.
- Each slot holds {live, pc, instr, tag, mask}.
- Reset (rst_n low, any time, asynchronous): head = tail = count = 0; all live bits = 0; deq_valid = 0; iqueue_full = 0. Payload outputs are don't-care while deq_valid = 0.
- iqueue_full is a combinational decode of the registered count. No combinational path from enq_valid.
- Enqueue: enq_valid & ~iqueue_full writes slot[tail] at the clock edge, sets live = 1, and increments tail and count.
  - enq_valid while full is dropped; flag it with a simulation assertion.
- Latency: an enqueued entry is visible on deq_* the next cycle.
- Dequeue handshake:
  - deq_valid = (count != 0) & slot[head].live & ~(br_broadcast & br_kill & slot[head].mask[br_tag]).
  - deq_valid & deq_ready pops the head: head+1, count-1.
- Dead head (count != 0 & ~slot[head].live) pops automatically at one entry per cycle, independent of deq_ready, with deq_valid = 0.
- Clean (br_broadcast & br_clean): clear mask[br_tag] in every slot at the edge. deq_mask shows the cleared bit in the same cycle.
- Kill (br_broadcast & br_kill): every slot with mask[br_tag] = 1 gets live = 0 at the edge. Pointers are unchanged; dead slots drain through the auto-pop.
- Simultaneous events:
  - Enqueue in the same cycle as a clean: the incoming mask has bit br_tag cleared before it is written.
  - Enqueue in the same cycle as a matching kill: the entry is written with live = 0, so it still consumes a slot.
  - Enqueue and pop in the same cycle: count is unchanged.
  - br_clean and br_kill both asserted: kill wins; assert this never occurs.
  - Flush: highest priority. Next cycle head = tail = count = 0 and all live = 0; enqueue, pop and broadcast in the flush cycle are ignored.
- Wrap-around: pointers wrap DEPTH-1 -> 0. Full and empty are distinguished only by count.

Optional Feature:
IQUEUE_BYPASS_EN:
- Defined: when count == 0 and enq_valid, the enq_* fields drive deq_* combinationally, with deq_valid = 1 unless a matching kill is present.
  - If deq_ready is also high, the entry is consumed and nothing is written; pointers and count are unchanged.
  - Otherwise the entry is written normally.
- Undefined: no bypass; minimum enqueue-to-dequeue latency is 1 cycle.

Test Plan:
- Reset, then enqueue pc 0x1000/0x1004/0x1008 with deq_ready = 0 -> count = 3. Raise deq_ready -> outputs 0x1000, 0x1004, 0x1008 in order on consecutive cycles, then deq_valid = 0.
- Enqueue 16 entries with deq_ready = 0 -> iqueue_full = 1 after the 16th. A 17th enq_valid is not stored. One pop -> iqueue_full = 0 the next cycle. Enqueue 4 more -> pointers wrap and FIFO order holds.
- Entries with masks 0x00, 0x04, 0x04, then clean with tag 2 -> all stored masks are 0x00; the head deq_mask shows 0x00 in the clean cycle.
- Entries A (mask 0x00), B (mask 0x02), C (mask 0x02), then kill with tag 1 -> only A is delivered. B and C auto-pop in 2 cycles with deq_valid = 0; count reaches 0.
- 5 entries queued, assert flush -> next cycle count = 0 and deq_valid = 0. Assert rst_n = 0 mid-cycle -> outputs clear without waiting for a clock edge.
- With IQUEUE_BYPASS_EN, queue empty, enq_valid and deq_ready high, pc 0x2000 -> deq_pc = 0x2000 in the same cycle and count stays 0. Without the macro -> deq_pc = 0x2000 one cycle later.
